wb_bus_watchdog: RTL and testbench

Wishbone stage between the Caravel user-area slave port and the address decoder that fans out to the FIR/mm/qs and UART targets. It forwards every management-SoC transaction downstream. If no target acknowledges within a bounded number of cycles, it terminates the transaction itself with an error word, so the CPU never hangs on an unmapped or dead address. It also exposes a two-register CSR window holding timeout statistics.

---
 rtl/wb_bus_watchdog_pkg.sv | 19 +
 rtl/wb_bus_watchdog_timeout_counter.sv | 35 +++
 rtl/wb_bus_watchdog.sv | 171 +++++++++++++++++
 tb/tb_wb_bus_watchdog.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bus_watchdog_pkg.sv
// Shared types and constants for the Wishbone bus watchdog.
// Holds the FSM state encoding, the CSR word offsets and the default error word.
package wb_watchdog_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [2:0]  CSR_TO_COUNT     = 3'd0;
    localparam logic [2:0]  CSR_LAST_ADDR    = 3'd4;
    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    function automatic logic csr_hit(input logic [31:0] adr, input logic [31:0] base);
        return (adr >= base) && (adr <= base + 32'd7);
    endfunction

endpackage

// File: rtl/wb_bus_watchdog_timeout_counter.sv
// Cycle counter for a forwarded transaction.
// The expired flag is raised while the count sits at TIMEOUT-1.
module wb_timeout_counter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int unsigned W = $clog2(TIMEOUT);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_bus_watchdog.sv
// Wishbone pass-through stage that answers unacknowledged transactions with an error word
// and keeps timeout statistics in a two-word local CSR window.
module wb_bus_watchdog
    import wb_watchdog_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA,
    parameter logic [31:0] CSR_BASE = 32'h3000_F000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        timeout_irq
);
    state_e      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] rdat_q, rdat_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        irq_q, irq_d;
    logic [15:0] to_count_q, to_count_d;
    logic [31:0] last_addr_q, last_addr_d;
    logic        cnt_clear, cnt_en, expired;
    logic        up_req, csr_sel;
    logic [2:0]  csr_off;

    assign up_req  = wbs_cyc_i & wbs_stb_i;
    assign csr_sel = csr_hit(wbs_adr_i, CSR_BASE);
    assign csr_off = (wbs_adr_i[2:0] - CSR_BASE[2:0]) & 3'b100;

    wb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout_counter (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .clear_i   (cnt_clear),
        .enable_i  (cnt_en),
        .expired_o (expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An upstream abort outranks a late ack, and an ack outranks expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (up_req) state_d = csr_sel ? RESP : FWD;
            FWD: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (wbm_ack_i || expired) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_d       = 1'b0;
        irq_d       = 1'b0;
        rdat_d      = rdat_q;
        req_d       = req_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        to_count_d  = to_count_q;
        last_addr_d = last_addr_q;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (up_req && csr_sel) begin
                    ack_d = 1'b1;
                    if (wbs_we_i) begin
                        rdat_d = '0;
                        if (csr_off == CSR_TO_COUNT) to_count_d = '0;
                    end else begin
                        rdat_d = (csr_off == CSR_LAST_ADDR) ? last_addr_q : {16'b0, to_count_q};
                    end
                end else if (up_req) begin
                    req_d     = 1'b1;
                    we_d      = wbs_we_i;
                    sel_d     = wbs_sel_i;
                    adr_d     = wbs_adr_i;
                    wdat_d    = wbs_dat_i;
                    cnt_clear = 1'b1;
                end
            end
            FWD: begin
                cnt_en = 1'b1;
                if (!wbs_cyc_i) begin
                    req_d = 1'b0;
                end else if (wbm_ack_i) begin
                    req_d  = 1'b0;
                    ack_d  = 1'b1;
                    rdat_d = wbm_dat_i;
                end else if (expired) begin
                    req_d       = 1'b0;
                    ack_d       = 1'b1;
                    irq_d       = 1'b1;
                    rdat_d      = ERR_DATA;
                    last_addr_d = adr_q;
                    to_count_d  = (to_count_q == 16'hFFFF) ? to_count_q : to_count_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q       <= 1'b0;
            irq_q       <= 1'b0;
            rdat_q      <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            wdat_q      <= '0;
            to_count_q  <= '0;
            last_addr_q <= '0;
        end else begin
            ack_q       <= ack_d;
            irq_q       <= irq_d;
            rdat_q      <= rdat_d;
            req_q       <= req_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            to_count_q  <= to_count_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = rdat_q;
    assign wbm_cyc_o   = req_q;
    assign wbm_stb_o   = req_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = wdat_q;
    assign timeout_irq = irq_q;

endmodule

// File: tb/tb_wb_bus_watchdog.sv
// Directed bench for wb_bus_watchdog with TIMEOUT=64 and hand-computed expectations.
// Cycle n counts clock edges after the request was driven; samples are taken #1 after each edge.
module tb_wb_bus_watchdog;

    localparam logic [31:0] CSR_BASE = 32'h3000_F000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        timeout_irq;

    int compared   = 0;
    int mismatched = 0;

    int          ack_at, irq_seen, stb_cycles, post_ack;
    logic [31:0] rdata;
    logic [31:0] seen_adr, seen_dat;
    logic [3:0]  seen_sel;
    logic        seen_we;
    int          n, late_ack, late_irq;

    wb_bus_watchdog #(.TIMEOUT(64), .ERR_DATA(32'hDEAD_BEEF), .CSR_BASE(CSR_BASE)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_dat_i   (wbm_dat_i),
        .timeout_irq (timeout_irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // One upstream transaction; ack_cycle is the cycle in which the downstream acks (0 = never).
    task automatic applyStimulus(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                                 input logic [3:0] sel, input int ack_cycle, input logic [31:0] ack_data);
        int k;
        ack_at = -1; rdata = '0; irq_seen = 0; stb_cycles = 0; k = 0;
        wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = wdat; wbs_sel_i = sel;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        while (k < 200) begin
            tick();
            k++;
            if (wbm_stb_o) stb_cycles++;
            if (timeout_irq) irq_seen++;
            if (k == 1) begin
                seen_adr = wbm_adr_o; seen_dat = wbm_dat_o; seen_sel = wbm_sel_o; seen_we = wbm_we_o;
            end
            if (wbs_ack_o) begin
                ack_at = k;
                rdata  = wbs_dat_o;
                break;
            end
            wbm_ack_i = (k == ack_cycle);
            wbm_dat_i = (k == ack_cycle) ? ack_data : 32'h0;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        tick();
        post_ack = int'(wbs_ack_o) + int'(timeout_irq);
    endtask

    task automatic readCsr(input string tag, input logic [31:0] adr, input logic [31:0] expected);
        applyStimulus(adr, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        checkOutput({tag, "_lat"}, ack_at, 32'd1);
        checkOutput(tag, rdata, expected);
    endtask

    initial begin
        wb_rst_i = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
        wbm_ack_i = 1'b0; wbm_dat_i = '0;
        tick(); tick();
        checkOutput("rst_ack", 32'(wbs_ack_o), 32'd0);
        checkOutput("rst_dat", wbs_dat_o, 32'd0);
        checkOutput("rst_req", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, timeout_irq}), 32'd0);
        checkOutput("rst_adr", wbm_adr_o, 32'd0);
        wb_rst_i = 1'b0;
        tick();

        readCsr("csr_cnt_init", CSR_BASE, 32'd0);
        readCsr("csr_last_init", CSR_BASE + 32'd4, 32'd0);

        applyStimulus(32'h3000_0000, 1'b0, 32'h0, 4'hF, 3, 32'h1234_5678);
        checkOutput("rd_lat", ack_at, 32'd4);
        checkOutput("rd_dat", rdata, 32'h1234_5678);
        checkOutput("rd_irq", irq_seen, 32'd0);
        checkOutput("rd_stb", stb_cycles, 32'd3);
        checkOutput("rd_adr", seen_adr, 32'h3000_0000);
        checkOutput("rd_one_ack", post_ack, 32'd0);

        applyStimulus(32'h3000_0010, 1'b1, 32'hAABB_CCDD, 4'b0011, 1, 32'h0);
        checkOutput("wr_lat", ack_at, 32'd2);
        checkOutput("wr_adr", seen_adr, 32'h3000_0010);
        checkOutput("wr_dat", seen_dat, 32'hAABB_CCDD);
        checkOutput("wr_sel_we", 32'({seen_sel, seen_we}), 32'({4'b0011, 1'b1}));

        applyStimulus(32'h3000_8000, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        checkOutput("to_lat", ack_at, 32'd65);
        checkOutput("to_dat", rdata, 32'hDEAD_BEEF);
        checkOutput("to_irq", irq_seen, 32'd1);
        checkOutput("to_stb", stb_cycles, 32'd64);
        checkOutput("to_post", post_ack, 32'd0);
        readCsr("to_cnt", CSR_BASE, 32'd1);
        readCsr("to_last", CSR_BASE + 32'd4, 32'h3000_8000);

        applyStimulus(32'h3000_4000, 1'b0, 32'h0, 4'hF, 64, 32'h0BAD_F00D);
        checkOutput("edge_lat", ack_at, 32'd65);
        checkOutput("edge_dat", rdata, 32'h0BAD_F00D);
        checkOutput("edge_irq", irq_seen, 32'd0);
        readCsr("edge_cnt", CSR_BASE, 32'd1);
        readCsr("edge_last", CSR_BASE + 32'd4, 32'h3000_8000);

        applyStimulus(32'h3000_9000, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        applyStimulus(32'h3000_A004, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        readCsr("cnt3", CSR_BASE, 32'd3);
        readCsr("last3", CSR_BASE + 32'd4, 32'h3000_A004);

        applyStimulus(CSR_BASE + 32'd4, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 32'h0);
        checkOutput("wlast_lat", ack_at, 32'd1);
        checkOutput("wlast_dat", rdata, 32'd0);
        readCsr("wlast_keep", CSR_BASE + 32'd4, 32'h3000_A004);

        applyStimulus(CSR_BASE, 1'b1, 32'h0, 4'hF, 0, 32'h0);
        checkOutput("clr_lat", ack_at, 32'd1);
        checkOutput("clr_dat", rdata, 32'd0);
        readCsr("clr_cnt", CSR_BASE, 32'd0);

        // Upstream abandons the forwarded request in cycle 10.
        wbs_adr_i = 32'h3000_0100; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        late_ack = 0; late_irq = 0;
        for (n = 1; n <= 10; n++) begin
            tick();
            late_ack += int'(wbs_ack_o);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick();
        checkOutput("abort_cyc", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
        for (n = 0; n < 80; n++) begin
            late_ack += int'(wbs_ack_o);
            late_irq += int'(timeout_irq);
            tick();
        end
        checkOutput("abort_ack", late_ack, 32'd0);
        checkOutput("abort_irq", late_irq, 32'd0);
        applyStimulus(32'h3000_0200, 1'b0, 32'h0, 4'hF, 2, 32'hCAFE_0001);
        checkOutput("abort_next_lat", ack_at, 32'd3);
        checkOutput("abort_next_dat", rdata, 32'hCAFE_0001);
        readCsr("abort_cnt", CSR_BASE, 32'd0);

        // Synchronous reset asserted while the request is waiting downstream.
        wbs_adr_i = 32'h3000_0300; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        for (n = 1; n <= 5; n++) tick();
        checkOutput("pre_rst_stb", 32'(wbm_stb_o), 32'd1);
        wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick();
        checkOutput("mrst_req", 32'({wbm_cyc_o, wbm_stb_o, wbs_ack_o, timeout_irq}), 32'd0);
        checkOutput("mrst_adr", wbm_adr_o, 32'd0);
        wb_rst_i = 1'b0;
        late_ack = 0; late_irq = 0;
        for (n = 0; n < 70; n++) begin
            tick();
            late_ack += int'(wbs_ack_o);
            late_irq += int'(timeout_irq);
        end
        checkOutput("mrst_noack", late_ack + late_irq, 32'd0);
        readCsr("mrst_last", CSR_BASE + 32'd4, 32'd0);
        applyStimulus(32'h3000_0400, 1'b0, 32'h0, 4'hF, 1, 32'h5555_AAAA);
        checkOutput("mrst_next_dat", rdata, 32'h5555_AAAA);

        // Preload the timeout counter one below saturation.
        force dut.to_count_q = 16'hFFFE;
        tick(); tick();
        release dut.to_count_q;
        applyStimulus(32'h3000_B000, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        checkOutput("sat_irq1", irq_seen, 32'd1);
        readCsr("sat_cnt1", CSR_BASE, 32'h0000_FFFF);
        applyStimulus(32'h3000_C000, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        checkOutput("sat_irq2", irq_seen, 32'd1);
        readCsr("sat_cnt2", CSR_BASE, 32'h0000_FFFF);
        readCsr("sat_last", CSR_BASE + 32'd4, 32'h3000_C000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
